// File: rtl/fft_pkg.sv
// Shared FFT types: complex sample packing, per-stage descriptor, streamer FSM states
// and the bit-reversal helper used for natural-order readout.
package fft_pkg;

  localparam int unsigned CPLX_W = 16;

  // re occupies the upper half of every packed {re, im} word
  typedef struct packed {
    logic signed [CPLX_W-1:0] re;
    logic signed [CPLX_W-1:0] im;
  } complex_t;

  typedef struct packed {
    logic [3:0] stage;
    logic       src_bank;
    logic       dst_bank;
  } stage_info_t;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } stream_state_t;

  function automatic int unsigned bitrev(input int unsigned k, input int unsigned bits);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < bits; i++) begin
      r = (r << 1) | ((k >> i) & 32'd1);
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_result_streamer_if.sv
// Output sample stream of the FFT result streamer: valid/ready plus sample, index, last.
interface fft_result_streamer_if #(
  parameter int unsigned N = 8
);
  import fft_pkg::*;

  localparam int unsigned AW = $clog2(N);

  logic          out_valid;
  logic          out_ready;
  complex_t      out_data;
  logic [AW-1:0] out_index;
  logic          out_last;

  modport master (
    output out_valid, out_data, out_index, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_index, out_last,
    output out_ready
  );

endinterface

// File: rtl/fifo2.sv
// Two-entry synchronous FIFO; head word stays stable until popped.
module fifo2 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

endmodule

// File: rtl/fft_result_streamer.sv
// Streams the N results of a finished FFT out of the selected result bank onto a
// valid/ready interface, optionally reading in bit-reversed order for natural output.
module fft_result_streamer
  import fft_pkg::*;
#(
  parameter int unsigned N           = 8,
  parameter int unsigned DATA_WIDTH  = CPLX_W,
  parameter bit          BIT_REVERSE = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    bank_in,
  output logic                    rd_en,
  output logic                    rd_bank,
  output logic [$clog2(N)-1:0]    rd_addr,
  input  logic [2*DATA_WIDTH-1:0] rd_data,
  output logic                    busy,
  output logic                    done,
  fft_result_streamer_if.master   out_if
);

  localparam int unsigned AW = $clog2(N);
  localparam int unsigned FW = 2*DATA_WIDTH + AW;
  localparam logic [AW:0] K_LIMIT = (AW+1)'(N);
  localparam logic [AW:0] K_LAST  = (AW+1)'(N-1);

  stream_state_t state;
  logic [AW:0]   k;
  logic [AW-1:0] issue_addr;
  logic [AW-1:0] last_addr;
  logic          inflight;
  logic [AW-1:0] inflight_idx;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [1:0]    fifo_count;
  logic [FW-1:0] fifo_wdata;
  logic [FW-1:0] fifo_rdata;
  logic [2:0]    credit_used;

  always_comb begin
    issue_addr = k[AW-1:0];
    if (BIT_REVERSE) begin
      issue_addr = AW'(bitrev(32'(k[AW-1:0]), AW));
    end
  end

  // Credit counts this cycle's pop so a stalled FIFO refills the same cycle ready rises;
  // that is why rd_en is combinational rather than registered.
  assign fifo_pop    = out_if.out_valid & out_if.out_ready;
  assign credit_used = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, fifo_pop};
  assign rd_en       = (state == READ) && (k < K_LIMIT) && (credit_used < 3'd2);
  assign rd_addr     = rd_en ? issue_addr : last_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      k            <= '0;
      rd_bank      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      last_addr    <= '0;
      inflight     <= 1'b0;
      inflight_idx <= '0;
    end else begin
      done     <= 1'b0;
      inflight <= rd_en;
      if (rd_en) begin
        inflight_idx <= k[AW-1:0];
        last_addr    <= issue_addr;
        k            <= k + 1'b1;
      end
      case (state)
        IDLE: begin
          if (start && !done) begin
            rd_bank <= bank_in;
            k       <= '0;
            busy    <= 1'b1;
            state   <= READ;
          end
        end
        READ: begin
          if (rd_en && (k == K_LAST)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // Finish on the edge that leaves FIFO and read pipe empty so done lands with the gap.
          if (credit_used == 3'd0) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign fifo_push  = inflight & (~fifo_full | fifo_pop);
  assign fifo_wdata = {inflight_idx, rd_data};

  fifo2 #(
    .WIDTH(FW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign out_if.out_valid = ~fifo_empty;
  assign out_if.out_data  = fifo_rdata[2*DATA_WIDTH-1:0];
  assign out_if.out_index = fifo_rdata[FW-1 -: AW];
  assign out_if.out_last  = (out_if.out_index == AW'(N-1));

endmodule

// File: tb/tb_fft_result_streamer.sv
// Bench for fft_result_streamer: natural-order and bit-reversed instances share stimulus
// and are checked each cycle against an index/address/data model of the transfer.
module tb_fft_result_streamer;
  import fft_pkg::*;

  localparam int unsigned N  = 8;
  localparam int unsigned AW = 3;
  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_n, start, bank_in, out_ready;
  logic          rd_en   [2];
  logic          rd_bank [2];
  logic [AW-1:0] rd_addr [2];
  logic [2*DW-1:0] rd_data [2];
  logic          busy    [2];
  logic          done    [2];

  fft_result_streamer_if #(.N(N)) s0 ();
  fft_result_streamer_if #(.N(N)) s1 ();
  assign s0.out_ready = out_ready;
  assign s1.out_ready = out_ready;

  fft_result_streamer #(.N(N), .DATA_WIDTH(DW), .BIT_REVERSE(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .bank_in(bank_in),
    .rd_en(rd_en[0]), .rd_bank(rd_bank[0]), .rd_addr(rd_addr[0]), .rd_data(rd_data[0]),
    .busy(busy[0]), .done(done[0]), .out_if(s0)
  );

  fft_result_streamer #(.N(N), .DATA_WIDTH(DW), .BIT_REVERSE(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .bank_in(bank_in),
    .rd_en(rd_en[1]), .rd_bank(rd_bank[1]), .rd_addr(rd_addr[1]), .rd_data(rd_data[1]),
    .busy(busy[1]), .done(done[1]), .out_if(s1)
  );

  logic          ov [2];
  complex_t      od [2];
  logic [AW-1:0] oi [2];
  logic          ol [2];
  assign ov[0] = s0.out_valid;  assign ov[1] = s1.out_valid;
  assign od[0] = s0.out_data;   assign od[1] = s1.out_data;
  assign oi[0] = s0.out_index;  assign oi[1] = s1.out_index;
  assign ol[0] = s0.out_last;   assign ol[1] = s1.out_last;

  // Result RAM: two banks, one-cycle read latency per instance
  logic [2*DW-1:0] mem [2][N];
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rd_en[d]) rd_data[d] <= mem[rd_bank[d]][rd_addr[d]];
    end
  end

  // Reference model state
  int unsigned br [N] = '{0, 4, 2, 6, 1, 5, 3, 7};
  logic [2*DW-1:0] exp_data [2][N];
  logic [2*DW-1:0] pop_log  [2][N];
  logic [AW+2*DW-1:0] held [2];
  logic [AW-1:0] last_addr [2];
  logic stall [2];
  logic model_bank;
  int iss [2];
  int pops [2];
  int done_cnt [2];
  logic done_seen [2];
  bit full_rate;
  int e_cnt, rel, p;
  int first_busy_rel, first_rd_rel, first_valid_rel, last_rel, done_rel;
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, want);
    end
  endtask

  function automatic int unsigned addr_of(input int d, input int k);
    int unsigned kk;
    kk = k % N;
    return (d == 1) ? br[kk] : kk;
  endfunction

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      rel = cyc - e_cnt + 1;
      for (int d = 0; d < 2; d++) begin
        if (stall[d]) begin
          chk("stall_valid", ov[d], 1'b1);
          chk("stall_hold", {oi[d], od[d]}, held[d]);
        end
        if (ov[d] && out_ready) begin
          chk("pop_count", pops[d] < N, 1'b1);
          p = pops[d] % N;
          chk("out_index", oi[d], p);
          chk("out_data", od[d], exp_data[d][p]);
          chk("out_last", ol[d], p == N-1);
          if (full_rate && d == 0) chk("k_cycle", rel, 3 + p);
          if (d == 0 && p == N-1) last_rel = rel;
          pop_log[d][p] = od[d];
          pops[d]++;
        end
        if (rd_en[d]) begin
          chk("rd_count", iss[d] < N, 1'b1);
          chk("rd_addr", rd_addr[d], addr_of(d, iss[d]));
          iss[d]++;
          chk("outstanding", (iss[d] - pops[d]) <= 2, 1'b1);
          last_addr[d] = rd_addr[d];
          if (d == 0 && first_rd_rel < 0) first_rd_rel = rel;
        end else begin
          chk("rd_addr_hold", rd_addr[d], last_addr[d]);
        end
        if (busy[d]) chk("rd_bank", rd_bank[d], model_bank);
        if (done[d]) begin
          chk("done_pops", pops[d], N);
          chk("done_busy", busy[d], 1'b0);
          done_seen[d] = 1'b1;
          done_cnt[d]++;
          if (d == 0) done_rel = rel;
        end
        if (d == 0 && busy[0] && first_busy_rel < 0) first_busy_rel = rel;
        if (d == 0 && ov[0] && first_valid_rel < 0) first_valid_rel = rel;
        stall[d] = ov[d] && !out_ready;
        held[d]  = {oi[d], od[d]};
      end
    end
  end

  task automatic fill_mem(input bit rnd);
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < N; k++) begin
        if (rnd) mem[b][k] = $urandom;
        else     mem[b][k] = {16'(b*16'h200 + k), 16'(16'h100 + b*16'h200 + k)};
      end
    end
  endtask

  task automatic arm(input logic bank);
    model_bank = bank;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < N; k++) exp_data[d][k] = mem[bank][addr_of(d, k)];
      iss[d] = 0;
      pops[d] = 0;
      done_cnt[d] = 0;
      done_seen[d] = 1'b0;
    end
    first_busy_rel = -1; first_rd_rel = -1; first_valid_rel = -1;
    last_rel = -1; done_rel = -1;
  endtask

  task automatic do_start(input logic bank);
    @(posedge clk); #1;
    arm(bank);
    e_cnt = cyc + 1;
    start = 1'b1;
    bank_in = bank;
    @(posedge clk); #1;
    start = 1'b0;
    bank_in = ~bank;
  endtask

  // mode 0: ready high, 1: ready pattern 1,0,0, 2: random ready plus stray starts
  task automatic wait_done(input int mode, input bit glitch, input bit timed);
    int c;
    c = 0;
    full_rate = timed;
    while (!(done_seen[0] && done_seen[1]) && c < 300) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (c % 3 == 0);
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (glitch && c == 2) begin
        start = 1'b1;
        bank_in = ~model_bank;
      end else if (mode == 2 && $urandom_range(0, 7) == 0) begin
        start = 1'b1;
        bank_in = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      c++;
    end
    start = 1'b0;
    full_rate = 1'b0;
    chk("done_timeout", done_seen[0] && done_seen[1], 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    chk("done_once0", done_cnt[0], 1);
    chk("done_once1", done_cnt[1], 1);
  endtask

  task automatic check_timing();
    chk("t_busy", first_busy_rel, 1);
    chk("t_rd_en", first_rd_rel, 1);
    chk("t_valid", first_valid_rel, 3);
    chk("t_last", last_rel, N + 2);
    chk("t_done", done_rel, N + 3);
  endtask

  task automatic check_zero();
    for (int d = 0; d < 2; d++) begin
      chk("zero_rd_en", rd_en[d], 1'b0);
      chk("zero_rd_bank", rd_bank[d], 1'b0);
      chk("zero_rd_addr", rd_addr[d], 0);
      chk("zero_valid", ov[d], 1'b0);
      chk("zero_data", od[d], 0);
      chk("zero_index", oi[d], 0);
      chk("zero_last", ol[d], 1'b0);
      chk("zero_busy", busy[d], 1'b0);
      chk("zero_done", done[d], 1'b0);
    end
  endtask

  initial begin
    int c;
    rst_n = 1'b0; start = 1'b0; bank_in = 1'b0; out_ready = 1'b0;
    full_rate = 1'b0; e_cnt = 0;
    for (int d = 0; d < 2; d++) begin
      stall[d] = 1'b0; last_addr[d] = '0;
    end
    fill_mem(1'b0);
    arm(1'b0);
    #12;
    check_zero();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Natural and bit-reversed readout at full rate, with literal data pins
    out_ready = 1'b1;
    do_start(1'b0);
    wait_done(0, 1'b0, 1'b1);
    check_timing();
    chk("pin_d0_k0", pop_log[0][0], 32'h0000_0100);
    chk("pin_d0_k7", pop_log[0][7], 32'h0007_0107);
    chk("pin_d1_k1", pop_log[1][1], 32'h0004_0104);
    chk("pin_d1_k6", pop_log[1][6], 32'h0003_0103);

    // Throttled sink, bank 1
    do_start(1'b1);
    wait_done(1, 1'b0, 1'b0);

    // Second start during READ with flipped bank must be ignored
    out_ready = 1'b1;
    do_start(1'b0);
    wait_done(0, 1'b1, 1'b1);

    // Reset mid-DRAIN with data waiting, then a clean transfer
    out_ready = 1'b1;
    do_start(1'b1);
    c = 0;
    while (iss[0] < N && c < 50) begin @(posedge clk); #1; c++; end
    out_ready = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("drain_valid", ov[0], 1'b1);
    chk("drain_busy", busy[0], 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero();
    for (int d = 0; d < 2; d++) begin
      stall[d] = 1'b0; last_addr[d] = '0;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    do_start(1'b0);
    wait_done(0, 1'b0, 1'b1);
    check_timing();

    // Bank 1 with sink stalled for 20 cycles
    out_ready = 1'b0;
    do_start(1'b1);
    repeat (20) begin @(posedge clk); #1; end
    chk("stall_reads0", iss[0], 2);
    chk("stall_reads1", iss[1], 2);
    chk("stall_bank0", rd_bank[0], 1'b1);
    chk("stall_bank1", rd_bank[1], 1'b1);
    chk("stall_ov", ov[0], 1'b1);
    chk("stall_idx", oi[0], 0);
    wait_done(0, 1'b0, 1'b0);

    // Randomized contents, banks and back-pressure
    for (int t = 0; t < 6; t++) begin
      fill_mem(1'b1);
      do_start(1'($urandom));
      wait_done(2, 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_result_streamer.md
# fft_result_streamer

Reads the N complex results of a completed FFT out of the final ping-pong result bank and presents them on a valid/ready stream, one sample per cycle when unthrottled. It sits beside the memory controller, triggered by the FFT engine's `finish` pulse, and drives a dedicated read port on the selected bank. Optional bit-reversed address generation delivers natural-order output.

## Interface
Parameters:
- `N`, 8: FFT length in complex samples; power of two, at least 4.
- `DATA_WIDTH`, 16: width of each real and imaginary part.
- `BIT_REVERSE`, 0: when 1, `rd_addr` is the bit-reversal of the output index.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  one-cycle pulse, driven from FFT `finish`.
- `bank_in`  in  1  bank holding the results (0 = mem0, 1 = mem1); sampled with `start`.
- `rd_en`  out  1  read strobe to the result RAM.
- `rd_bank`  out  1  registered copy of `bank_in`, held for the whole transfer.
- `rd_addr`  out  $clog2(N)  read address.
- `rd_data`  in  2*DATA_WIDTH  RAM read data as {re, im}; valid exactly one cycle after `rd_en`.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  sink accepts; a transfer occurs when valid and ready are both high.
- `out_data`  out  complex_t  sample (re, im).
- `out_index`  out  $clog2(N)  natural output index k, 0..N-1.
- `out_last`  out  1  high with index N-1.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle pulse after the last transfer.

## Operation
- The FSM has three states: IDLE, READ and DRAIN.
  - IDLE: `start` captures `bank_in` into `rd_bank` and clears the issue counter. The next state is READ.
  - READ: issues reads for k = 0..N-1. After issuing k = N-1, the next state is DRAIN.
  - DRAIN: waits until the FIFO is empty and nothing is in flight. It then pulses `done` and returns to IDLE.
- `busy` is high in READ and DRAIN.
- Address: `rd_addr` = k when `BIT_REVERSE`=0, otherwise bitrev(k) over $clog2(N) bits.
  - `rd_addr` holds its value when `rd_en` is low.
- Output buffer: a 2-entry FIFO. The FIFO stores data plus index.
  - `rd_data` is written into the FIFO the cycle after `rd_en`.
  - The index for each entry comes from a registered copy of the issued k.
- Credit rule: `rd_en` is asserted only when all of the following hold:
  - the state is READ;
  - k has not passed N-1;
  - (fifo_count + inflight − pop) < 2, where pop = `out_valid` & `out_ready` this cycle.
  - This rule never overflows the FIFO, and it allows throughput of 1 per cycle.
- `out_valid` = FIFO not empty. `out_data` and `out_index` come from the FIFO head. `out_last` = head index equals N-1.
- Once `out_valid` is raised, `out_data` and `out_index` stay stable until the transfer completes.
- `start` while `busy` is ignored; `bank_in` is not re-sampled.
- `start` coinciding with the `done` cycle is also ignored.
- Data is passed through unmodified; there is no scaling or arithmetic.

## Timing
- Reset values: `rd_en`=0, `rd_bank`=0, `rd_addr`=0, `out_valid`=0, `out_data`=0, `out_index`=0, `out_last`=0, `busy`=0, `done`=0. The FIFO is empty and the state is IDLE.
- Asserting `rst_n` low mid-transfer aborts at once. All of the above values apply asynchronously, and the in-flight read is discarded.
- Latency from `start` sampled at edge E:
  - `busy` and the first `rd_en` are high in cycle E+1.
  - The first `out_valid` is in cycle E+3.
- With `out_ready` held high:
  - index k is presented in cycle E+3+k;
  - `out_last` is in cycle E+N+2;
  - `done` is in cycle E+N+3, and `busy` falls in the same cycle.
- Back-pressure: with `out_ready` low, at most 2 reads are outstanding, and `rd_en` stays low after that.
  - After `out_ready` rises, the first pop occurs in the same cycle.
  - A new `rd_en` may assert in that same cycle.
- `rd_bank` is stable from E+1 until `busy` falls.

## Structure
- `complex_t`, `stage_info_t` and a `bitrev` function belong in a shared package `fft_pkg`. The FFT modules use the same package.
- The {re, im} packing order (re in the upper half) is a package-level convention.
- One sub-module: `fifo2`, a 2-entry synchronous FIFO.
  - Parameterized width; async active-low reset.
  - Ports: push, pop, full, empty, count.

## Test plan
- N=8, `BIT_REVERSE`=0, RAM preloaded with {re=k, im=0x100+k}, `out_ready`=1 → 8 transfers with index 0..7 and matching data in cycles E+3..E+10; `out_last` at index 7; `done` at E+11.
- Same run with `BIT_REVERSE`=1 → `rd_addr` sequence 0,4,2,6,1,5,3,7; `out_index` 0..7; `out_data` = RAM[bitrev(k)].
- `out_ready` toggled 1,0,0,1,… → no sample lost or duplicated; data is stable while stalled; `rd_en` never exceeds 2 outstanding.
- `start` pulsed again during READ with `bank_in` flipped → ignored; `rd_bank` unchanged; exactly 8 transfers.
- `rst_n` dropped mid-DRAIN with `out_valid` high → all outputs are 0 immediately; a new `start` afterwards produces a full, correct transfer.
- `bank_in`=1 with `out_ready` low for 20 cycles after start → `rd_bank`=1 throughout; exactly 2 `rd_en` pulses; `out_valid` high holding index 0.
